// File: rtl/rx_data_sampler.sv
// UART receive front end on the 16x Baud_Clk: qualifies the start bit, samples data bits at centre,
// and opens the stop-bit window. Optional parity stage enabled by macro PARITY_EN.
module rx_data_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic        Baud_Clk,
  input  logic        Reset,
  input  logic        Rx_In,
  output logic [31:0] Rx_data,
  output logic        Check_Stop,
  output logic        Data_Ready,
  output logic        Rx_Busy,
  output logic        Start_Error,
  output logic        Parity_Error
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] TICK_MID  = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] BIT_LAST  = 5'(DATA_BITS - 1);
`ifdef PARITY_EN
  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - DATA_BITS);
`endif

  state_t     state;
  logic [4:0] tick;
  logic [4:0] bitn;
  logic       rx_m;
  logic       rxs;
  logic [1:0] sync_vld;
  logic       armed;

  // sync_vld keeps the reset value of the synchroniser from arming the receiver;
  // only a genuinely sampled high line may set armed.
  always_ff @(posedge Baud_Clk) begin
    if (Reset) begin
      state       <= IDLE;
      tick        <= '0;
      bitn        <= '0;
      rx_m        <= 1'b1;
      rxs         <= 1'b1;
      sync_vld    <= '0;
      armed       <= 1'b0;
      Rx_data     <= '0;
      Check_Stop  <= 1'b0;
      Data_Ready  <= 1'b0;
      Rx_Busy     <= 1'b0;
      Start_Error <= 1'b0;
`ifdef PARITY_EN
      Parity_Error <= 1'b0;
`endif
    end else begin
      rx_m        <= Rx_In;
      rxs         <= rx_m;
      sync_vld    <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rxs)
        armed <= 1'b1;
      Data_Ready  <= 1'b0;
      Start_Error <= 1'b0;
      tick        <= (tick == TICK_LAST) ? '0 : tick + 5'd1;

      case (state)
        IDLE: begin
          tick <= '0;
          if (armed && !rxs) begin
            state   <= START;
            Rx_Busy <= 1'b1;
          end
        end
        START: begin
          if (tick == TICK_MID) begin
            tick <= '0;
            if (!rxs) begin
              Rx_data <= '0;
              bitn    <= '0;
`ifdef PARITY_EN
              Parity_Error <= 1'b0;
`endif
              state   <= DATA;
            end else begin
              Start_Error <= 1'b1;
              Rx_Busy     <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick == TICK_LAST) begin
            Rx_data[bitn] <= rxs;
            if (bitn == BIT_LAST) begin
`ifdef PARITY_EN
              state <= PARITY;
`else
              state      <= STOP;
              Check_Stop <= 1'b1;
              Data_Ready <= 1'b1;
`endif
            end else begin
              bitn <= bitn + 5'd1;
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (tick == TICK_LAST) begin
            Parity_Error <= (^(Rx_data & DATA_MASK)) ^ rxs ^ 1'(PARITY_ODD);
            state        <= STOP;
            Check_Stop   <= 1'b1;
            Data_Ready   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick == TICK_LAST) begin
            Check_Stop <= 1'b0;
            Rx_Busy    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          Rx_Busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef PARITY_EN
  assign Parity_Error = 1'b0;
`endif

endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed bench for rx_data_sampler: frames are driven on the line, expected words queued,
// and popped when Data_Ready fires.
module tb_rx_data_sampler;

  localparam int OS = 16;

  logic        Baud_Clk = 1'b0;
  logic        Reset    = 1'b1;
  logic        Rx_In    = 1'b1;
  logic [31:0] Rx_data;
  logic        Check_Stop, Data_Ready, Rx_Busy, Start_Error, Parity_Error;

  int checks = 0;
  int errors = 0;
  int dr_cnt = 0;
  int se_cnt = 0;
  logic [31:0] sb[$];

  rx_data_sampler #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .Baud_Clk    (Baud_Clk),
    .Reset       (Reset),
    .Rx_In       (Rx_In),
    .Rx_data     (Rx_data),
    .Check_Stop  (Check_Stop),
    .Data_Ready  (Data_Ready),
    .Rx_Busy     (Rx_Busy),
    .Start_Error (Start_Error),
    .Parity_Error(Parity_Error)
  );

  always #5 Baud_Clk = ~Baud_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic cs_prev = 1'b0;
  int   cs_run  = 0;
  always @(negedge Baud_Clk) begin
    if (Reset) begin
      cs_prev = 1'b0;
      cs_run  = 0;
    end else begin
      if (Data_Ready) begin
        dr_cnt++;
        chk("dr_on_cs_rise", 32'(Check_Stop && !cs_prev), 32'd1);
        chk("dr_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("rx_data", Rx_data, sb.pop_front());
      end
      if (Check_Stop) cs_run++;
      else if (cs_prev) begin
        chk("cs_len", 32'(cs_run), 32'(OS));
        cs_run = 0;
      end
      if (Start_Error) se_cnt++;
      cs_prev = Check_Stop;
    end
  end

  task automatic drive(input logic b, input int n);
    Rx_In = b;
    repeat (n) @(negedge Baud_Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip);
    sb.push_back({24'h0, d});
    drive(1'b0, OS);
    chk("busy_in_frame", 32'(Rx_Busy), 32'd1);
    for (int i = 0; i < 8; i++) drive(d[i], OS);
`ifdef PARITY_EN
    drive((^d) ^ pflip, OS);
`endif
    drive(1'b1, OS);
    drive(1'b1, 20);
  endtask

  initial begin
    int busy_seen;
    int dr0, se0;
    logic [7:0] ab;

    // reset with idle line
    Reset = 1'b1; Rx_In = 1'b1;
    repeat (5) @(negedge Baud_Clk);
    chk("rst_rx_data", Rx_data, 32'h0);
    chk("rst_flags", {27'h0, Check_Stop, Data_Ready, Rx_Busy, Start_Error, Parity_Error}, 32'h0);
    Reset = 1'b0;
    busy_seen = 0;
    repeat (100) begin
      @(negedge Baud_Clk);
      if (Rx_Busy) busy_seen++;
    end
    chk("idle_busy", 32'(busy_seen), 32'd0);

    // good frame 0xA5
    dr0 = dr_cnt;
    send_frame(8'hA5, 1'b0);
    chk("a5_dr_once", 32'(dr_cnt - dr0), 32'd1);
    chk("a5_word", Rx_data, 32'h0000_00A5);
    chk("a5_busy_after", 32'(Rx_Busy), 32'd0);

    // start glitch
    se0 = se_cnt;
    drive(1'b0, 4);
    drive(1'b1, 40);
    chk("glitch_se_once", 32'(se_cnt - se0), 32'd1);
    chk("glitch_busy", 32'(Rx_Busy), 32'd0);
    chk("glitch_rx_data", Rx_data, 32'h0000_00A5);

    // reset in the middle of bit 3
    ab = 8'hF5;
    dr0 = dr_cnt;
    drive(1'b0, OS);
    for (int i = 0; i < 3; i++) drive(ab[i], OS);
    drive(ab[3], OS / 2);
    chk("abort_busy_pre", 32'(Rx_Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Baud_Clk);
    chk("abort_rx_data", Rx_data, 32'h0);
    chk("abort_busy", 32'(Rx_Busy), 32'd0);
    Reset = 1'b0;
    drive(1'b1, 5 * OS);
    chk("abort_no_dr", 32'(dr_cnt - dr0), 32'd0);
    send_frame(8'h3C, 1'b0);
    chk("3c_word", Rx_data, 32'h0000_003C);

`ifdef PARITY_EN
    send_frame(8'h07, 1'b0);
    chk("par_ok", 32'(Parity_Error), 32'd0);
    send_frame(8'h07, 1'b1);
    chk("par_bad", 32'(Parity_Error), 32'd1);
`else
    chk("par_tied", 32'(Parity_Error), 32'd0);
`endif

    // line held low across reset release
    se0 = se_cnt;
    Rx_In = 1'b0;
    Reset = 1'b1;
    repeat (5) @(negedge Baud_Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Baud_Clk);
    chk("low_rst_busy", 32'(Rx_Busy), 32'd0);
    chk("low_rst_se", 32'(se_cnt - se0), 32'd0);
    drive(1'b1, 20);
    send_frame(8'hFF, 1'b0);
    chk("ff_word", Rx_data, 32'h0000_00FF);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
